vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
//
// PURPOSE
//   Owns the 80x60-cell, 3-bit-colour video memory and shares its single write
//   port between two requesters (0: pattern/flag painter, 1: PS/2 keyboard path)
//   using round-robin arbitration with a req/ack handshake. Provides a
//   fixed-latency read port to the VGA scan path and, optionally, a hardware
//   clear-screen sequencer. Sits between the vga timing block and the writers.
//
// PARAMETERS
//   COLS   80   cells per row; x range 0..COLS-1
//   ROWS   60   rows; y range 0..ROWS-1
//   CW     3    colour width, {R,G,B}
//
// PORTS
//   clk        in   1    system clock; all logic on posedge
//   rst_n      in   1    asynchronous active-low reset
//   rd_x       in   7    display read column (hpos>>3)
//   rd_y       in   6    display read row (vpos>>3)
//   rd_data    out  CW   colour of cell (rd_x,rd_y); 1-cycle latency
//   req0/req1  in   1    write request, requester 0/1
//   x0/x1      in   7    write column
//   y0/y1      in   6    write row
//   d0/d1      in   CW   write colour
//   ack0/ack1  out  1    one-cycle write-done pulse
//   clr_req    in   1    start clear-screen (single-cycle pulse)
//   clr_color  in   CW   fill colour for clear
//   busy       out  1    clear sequence in progress
//
// BEHAVIOUR
//   - Address = y*COLS + x (linear, 0..COLS*ROWS-1); no bit concatenation.
//   - Reset: ack0=ack1=0, rd_data=0, busy=0, state=IDLE, last_grant=1 (so
//     port 0 wins the first tie). Memory contents are NOT reset.
//   - Read: rd_data registered on the edge after rd_x/rd_y are presented. Reads
//     never stall, including during clear. Out-of-range (x>=COLS or y>=ROWS) -> 0.
//   - Handshake: requester holds req, x, y, d stable until it sees ack. A
//     requester whose ack is high this cycle is masked from grant, so an
//     ack-then-drop requester is never written twice.
//   - Arbitration (IDLE): on each edge, eligible = req & ~ack. One eligible ->
//     grant it. Both -> grant the one != last_grant. Granted port: memory
//     written at that edge, ack_i=1 for the following cycle, last_grant=i.
//     At most one write per cycle; max throughput 1 write/cycle aggregate.
//   - Out-of-range write coordinates: acked normally, memory unchanged.
//   - FSM: IDLE -> CLEAR on clr_req (only when macro enabled); CLEAR writes
//     clr_color to addr 0,1,..,COLS*ROWS-1, one per cycle; after the last
//     address -> IDLE. busy=1 for exactly COLS*ROWS cycles starting the edge
//     after clr_req. No acks issued in CLEAR; pending reqs wait.
//   - clr_req arriving while busy: ignored. clr_req and a write req on the
//     same edge in IDLE: clear wins, write deferred until CLEAR completes.
//   - rst_n asserted mid-clear: immediate return to IDLE, busy=0, partial fill
//     left in memory.
//
// CONFIGURATION
//   VRAM_CLEAR_EN  defined: CLEAR state, address counter and busy logic built.
//                  undefined: clr_req/clr_color ignored, busy tied 0, FSM is
//                  IDLE-only; arbitration and reads unchanged.
//
// TESTING
//   1 Reset: rst_n=0 mid-activity -> ack0/1=0, rd_data=0, busy=0 asynchronously.
//   2 req0 x0=5 y0=2 d0=3'b100 -> ack0 one cycle; read (5,2) -> 3'b100 next cycle.
//   3 req0,req1 held continuously -> acks alternate ack0,ack1,ack0...; each
//     requester written once per handshake, no double writes.
//   4 req1 x1=80 y1=0 d1=3'b111 -> ack1 pulses; read (79,0),(0,1) unchanged;
//     read (80,0) returns 0.
//   5 (VRAM_CLEAR_EN) clr_req, clr_color=3'b001 -> busy high 4800 cycles; req0
//     during clear acked only after busy falls; all cells read 3'b001 except
//     req0's cell.
//   6 (VRAM_CLEAR_EN) rst_n pulsed at clear cycle 100 -> busy=0, cells 0..99
//     = clr_color, subsequent req0 acked in 1 cycle.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: owns the COLS x ROWS cell video memory. One write port is shared
// round-robin between two req/ack requesters. The VGA scan path gets a read port
// with one cycle of latency that never stalls. An optional clear-screen sequencer
// is built when VRAM_CLEAR_EN is defined; without it the FSM only has IDLE and
// busy is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrating requester writes; accepts clr_req
// CLEAR | writing clr_color to every address in turn; no grants issued
module vram_arbiter #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int CW   = 3,
  parameter int XW   = 7,
  parameter int YW   = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic [CW-1:0] rd_data,
  input  logic          req0,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [CW-1:0] d0,
  output logic          ack0,
  input  logic          req1,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] d1,
  output logic          ack1,
  input  logic          clr_req,
  input  logic [CW-1:0] clr_color,
  output logic          busy
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] mem [DEPTH];
  logic          last_grant_q;
  logic          elig0, elig1;
  logic          grant0, grant1;
  logic          we;
  logic [AW-1:0] waddr;
  logic [CW-1:0] wdata;
  logic          start_clr;

  function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (x < XW'(COLS)) && (y < YW'(ROWS));
  endfunction

  // Linear address y*COLS + x; only meaningful when in_range() holds.
  function automatic logic [AW-1:0] lin_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(COLS) + AW'(x);
  endfunction

  // A requester still showing ack this cycle is masked so it is not written twice.
  assign elig0 = req0 & ~ack0;
  assign elig1 = req1 & ~ack1;

`ifdef VRAM_CLEAR_EN
  logic [AW-1:0] clr_addr_q;
  logic [CW-1:0] clr_color_q;

  assign start_clr = clr_req && (state_q == IDLE);
  assign busy      = (state_q == CLEAR);

  // Clear address walks 0..DEPTH-1; fill colour captured when the clear starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_q  <= '0;
      clr_color_q <= '0;
    end else if (start_clr) begin
      clr_addr_q  <= '0;
      clr_color_q <= clr_color;
    end else if (state_q == CLEAR) begin
      clr_addr_q  <= clr_addr_q + 1'b1;
    end
  end
`else
  logic unused_clr;

  assign start_clr  = 1'b0;
  assign busy       = 1'b0;
  assign unused_clr = ^{clr_req, clr_color};
`endif

  // Next state, grant selection and write-port mux.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    case (state_q)
      IDLE: begin
        if (start_clr) begin
          state_d = CLEAR;
        end else begin
          if (elig0 && elig1) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
          end else begin
            grant0 = elig0;
            grant1 = elig1;
          end
          if (grant0) begin
            we    = in_range(x0, y0);
            waddr = lin_addr(x0, y0);
            wdata = d0;
          end else if (grant1) begin
            we    = in_range(x1, y1);
            waddr = lin_addr(x1, y1);
            wdata = d1;
          end
        end
      end
      CLEAR: begin
`ifdef VRAM_CLEAR_EN
        we    = 1'b1;
        waddr = clr_addr_q;
        wdata = clr_color_q;
        if (clr_addr_q == AW'(DEPTH - 1)) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, ack pulses and round-robin history; last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ack0    <= grant0;
      ack1    <= grant1;
      if (grant0)      last_grant_q <= 1'b0;
      else if (grant1) last_grant_q <= 1'b1;
    end
  end

  // Registered read; off-screen coordinates read as colour 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (in_range(rd_x, rd_y)) begin
      rd_data <= mem[lin_addr(rd_x, rd_y)];
    end else begin
      rd_data <= '0;
    end
  end

  // Single memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter; clear-screen checks built when VRAM_CLEAR_EN is defined.
module tb_vram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] rd_x, x0, x1;
  logic [5:0] rd_y, y0, y1;
  logic [2:0] rd_data, d0, d1, clr_color;
  logic       req0, req1, ack0, ack1, clr_req, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .req0(req0), .x0(x0), .y0(y0), .d0(d0), .ack0(ack0),
    .req1(req1), .x1(x1), .y1(y1), .d1(d1), .ack1(ack1),
    .clr_req(clr_req), .clr_color(clr_color), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Idle one cycle, then request and wait up to 20 cycles for the ack.
  task automatic do_write(input int port, input logic [6:0] x, input logic [5:0] y,
                          input logic [2:0] d, output int cycles);
    @(posedge clk); #1;
    cycles = 99;
    if (port == 0) begin req0 = 1'b1; x0 = x; y0 = y; d0 = d; end
    else           begin req1 = 1'b1; x1 = x; y1 = y; d1 = d; end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        cycles = i;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] x, input logic [5:0] y, input logic [2:0] exp,
                         input string tag);
    rd_x = x;
    rd_y = y;
    @(posedge clk); #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst_n = 1'b0;
    rd_x = '0; rd_y = '0;
    req0 = 1'b0; x0 = '0; y0 = '0; d0 = '0;
    req1 = 1'b0; x1 = '0; y1 = '0; d1 = '0;
    clr_req = 1'b0; clr_color = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk) rst_n = 1'b1;

    // First tie after reset goes to port 0, then port 1.
    @(posedge clk); #1;
    req0 = 1'b1; x0 = 7'd1; y0 = 6'd0; d0 = 3'd3;
    req1 = 1'b1; x1 = 7'd2; y1 = 6'd0; d1 = 3'd5;
    @(posedge clk); #1;
    chk("tie_ack0", 32'(ack0), 1);
    chk("tie_ack1_low", 32'(ack1), 0);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("tie_ack0_drop", 32'(ack0), 0);
    chk("tie_ack1", 32'(ack1), 1);
    req1 = 1'b0;
    do_read(7'd1, 6'd0, 3'd3, "tie_rd_p0");
    do_read(7'd2, 6'd0, 3'd5, "tie_rd_p1");

    // Single write from port 0.
    do_write(0, 7'd5, 6'd2, 3'b100, c);
    chk("w0_latency", 32'(c), 1);
    @(posedge clk); #1;
    chk("w0_ack_pulse", 32'(ack0), 0);
    do_read(7'd5, 6'd2, 3'b100, "w0_rd");

    // Both held continuously: last grant was port 0, so port 1 leads and they alternate.
    @(posedge clk); #1;
    req0 = 1'b1; x0 = 7'd10; y0 = 6'd3; d0 = 3'd2;
    req1 = 1'b1; x1 = 7'd11; y1 = 6'd3; d1 = 3'd5;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rr_ack0_%0d", i), 32'(ack0), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_ack1_%0d", i), 32'(ack1), (i % 2 == 1) ? 1 : 0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk); #1;
    chk("rr_ack0_end", 32'(ack0), 0);
    chk("rr_ack1_end", 32'(ack1), 0);
    do_read(7'd10, 6'd3, 3'd2, "rr_rd_p0");
    do_read(7'd11, 6'd3, 3'd5, "rr_rd_p1");

    // Out-of-range write x=80 aliases address 80 = (0,1) if decoded naively.
    do_write(0, 7'd79, 6'd0, 3'd3, c);
    do_write(0, 7'd0, 6'd1, 3'd6, c);
    do_write(1, 7'd80, 6'd0, 3'b111, c);
    chk("oor_ack1", 32'(c), 1);
    do_read(7'd79, 6'd0, 3'd3, "oor_rd_79_0");
    do_read(7'd0, 6'd1, 3'd6, "oor_rd_0_1");
    do_read(7'd80, 6'd0, 3'd0, "oor_rd_80_0");
    do_read(7'd0, 6'd60, 3'd0, "oor_rd_0_60");

    // Asynchronous reset while an ack and read data are live.
    rd_x = 7'd5; rd_y = 6'd2;
    req0 = 1'b1; x0 = 7'd1; y0 = 6'd1; d0 = 3'd1;
    @(posedge clk); #1;
    chk("pre_rst_ack0", 32'(ack0), 1);
    chk("pre_rst_rd", 32'(rd_data), 3'b100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ack0", 32'(ack0), 0);
    chk("async_rst_ack1", 32'(ack1), 0);
    chk("async_rst_rd", 32'(rd_data), 0);
    chk("async_rst_busy", 32'(busy), 0);
    req0 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    do_read(7'd5, 6'd2, 3'b100, "mem_kept_rd");

`ifdef VRAM_CLEAR_EN
    begin
      int busy_cnt;
      int ack_busy;
      int w;
      // Clear and a write request on the same edge: clear wins, write waits.
      @(posedge clk); #1;
      clr_color = 3'b001; clr_req = 1'b1;
      req0 = 1'b1; x0 = 7'd20; y0 = 6'd20; d0 = 3'd6;
      @(posedge clk); #1;
      clr_req = 1'b0;
      chk("clr_busy_rise", 32'(busy), 1);
      chk("clr_no_ack_start", 32'(ack0), 0);
      busy_cnt = 1;
      ack_busy = 0;
      for (int i = 0; i < 6000; i++) begin
        @(posedge clk); #1;
        if (!busy) break;
        busy_cnt++;
        if (ack0) ack_busy++;
      end
      chk("clr_busy_cycles", 32'(busy_cnt), 4800);
      chk("clr_ack_during_busy", 32'(ack_busy), 0);
      chk("clr_ack_at_fall", 32'(ack0), 0);
      w = 99;
      for (int i = 1; i <= 10; i++) begin
        @(posedge clk); #1;
        if (ack0) begin w = i; break; end
      end
      chk("clr_deferred_ack", 32'(w), 1);
      req0 = 1'b0;
      for (int y = 0; y < 60; y++)
        for (int x = 0; x < 80; x++)
          do_read(7'(x), 6'(y), (x == 20 && y == 20) ? 3'd6 : 3'd1,
                  $sformatf("clr_fill_%0d_%0d", x, y));

      // Reset after 100 clear writes leaves cells 0..99 filled, the rest untouched.
      @(posedge clk); #1;
      clr_color = 3'b010; clr_req = 1'b1;
      @(posedge clk); #1;
      clr_req = 1'b0;
      repeat (100) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("clr_rst_busy", 32'(busy), 0);
      @(negedge clk) rst_n = 1'b1;
      for (int a = 0; a <= 100; a++)
        do_read(7'(a % 80), 6'(a / 80), (a < 100) ? 3'd2 : 3'd1,
                $sformatf("partial_%0d", a));
      do_write(0, 7'd30, 6'd30, 3'd5, c);
      chk("post_clr_rst_ack", 32'(c), 1);
      do_read(7'd30, 6'd30, 3'd5, "post_clr_rst_rd");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
